// File: rtl/fifo_prog_pkg.sv
// Shared definitions for the programmable FIFO: default geometry, read mode
// and the count-width helper used by the top, its RAM and the interface.
package fifo_prog_pkg;

  localparam int FIFO_WIDTH_DEF = 16;
  localparam int FIFO_DEPTH_DEF = 8;

  typedef enum logic {
    MODE_STD  = 1'b0,
    MODE_FWFT = 1'b1
  } fifo_mode_e;

  // Occupancy must represent 0..depth inclusive, hence one bit above the pointer width.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_prog_if.sv
// Handshake, data, status and threshold bundle between a FIFO and its user.
// The producer/consumer side takes the master modport, the FIFO the slave.
interface fifo_prog_if
  import fifo_prog_pkg::*;
#(
  parameter int FIFO_WIDTH = FIFO_WIDTH_DEF,
  parameter int CNT_W      = cnt_w(FIFO_DEPTH_DEF)
);

  logic                  flush;
  logic [FIFO_WIDTH-1:0] data_in;
  logic                  wr_en;
  logic                  rd_en;
  logic [CNT_W-1:0]      af_thresh;
  logic [CNT_W-1:0]      ae_thresh;
  logic [FIFO_WIDTH-1:0] data_out;
  logic [CNT_W-1:0]      count;
  logic                  full;
  logic                  empty;
  logic                  almostfull;
  logic                  almostempty;
  logic                  wr_ack;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output flush, data_in, wr_en, rd_en, af_thresh, ae_thresh,
    input  data_out, count, full, empty, almostfull, almostempty,
           wr_ack, overflow, underflow
  );

  modport slave (
    input  flush, data_in, wr_en, rd_en, af_thresh, ae_thresh,
    output data_out, count, full, empty, almostfull, almostempty,
           wr_ack, overflow, underflow
  );

  modport monitor (
    input flush, data_in, wr_en, rd_en, af_thresh, ae_thresh,
          data_out, count, full, empty, almostfull, almostempty,
          wr_ack, overflow, underflow
  );

endinterface

// File: rtl/fifo_prog_ram.sv
// Simple dual-port storage: one write port, one registered read port with a
// synchronous clear on the read register only.
module fifo_prog_ram #(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: the array has no reset so it can map onto RAM macros; only the read register clears.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/fifo_prog.sv
// Synchronous FIFO with occupancy count, live almost-full/empty thresholds,
// flush, and either a registered read or a first-word-fall-through head.
module fifo_prog
  import fifo_prog_pkg::*;
#(
  parameter int FIFO_WIDTH = FIFO_WIDTH_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int FWFT       = 0
) (
  input  logic       clk,
  input  logic       rst,
  fifo_prog_if.slave bus
);

  localparam int         CNT_W = cnt_w(FIFO_DEPTH);
  localparam int         PTR_W = $clog2(FIFO_DEPTH);
  localparam fifo_mode_e MODE  = (FWFT != 0) ? MODE_FWFT : MODE_STD;

  if (FIFO_DEPTH < 4 || FIFO_WIDTH < 1) begin : g_param_check
    $error("fifo_prog: FIFO_DEPTH must be >= 4 and FIFO_WIDTH >= 1");
  end

  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      rd_ptr_n;
  logic [PTR_W-1:0]      ram_raddr;
  logic [CNT_W-1:0]      count;
  logic                  clr;
  logic                  full;
  logic                  empty;
  logic                  wr_acc;
  logic                  rd_acc;
  logic                  ram_we;
  logic                  ram_re;
  logic [FIFO_WIDTH-1:0] ram_rdata;
  logic                  fwd_hit;
  logic                  fwd_q;
  logic [FIFO_WIDTH-1:0] fwd_data;
  logic                  wr_ack;
  logic                  overflow;
  logic                  underflow;

  // Depth need not be a power of two, so wrap by comparison.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign clr      = rst | bus.flush;
  assign full     = (count == CNT_W'(FIFO_DEPTH));
  assign empty    = (count == '0);
  assign rd_acc   = bus.rd_en & ~empty;
  assign wr_acc   = bus.wr_en & (~full | rd_acc);
  assign rd_ptr_n = rd_acc ? ptr_inc(rd_ptr) : rd_ptr;
  assign ram_we   = wr_acc & ~clr;

  // A write landing on next cycle's head slot cannot be seen through the RAM
  // read register in time, so it is captured beside it instead.
  assign fwd_hit  = (MODE == MODE_FWFT) && wr_acc && (wr_ptr == rd_ptr_n);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    ram_re    = rd_acc;
    ram_raddr = rd_ptr;
    if (MODE == MODE_FWFT) begin
      ram_re    = 1'b1;
      ram_raddr = rd_ptr_n;
    end
  end

  fifo_prog_ram #(
    .WIDTH  (FIFO_WIDTH),
    .DEPTH  (FIFO_DEPTH),
    .ADDR_W (PTR_W)
  ) u_ram (
    .clk   (clk),
    .clr   (clr),
    .we    (ram_we),
    .waddr (wr_ptr),
    .wdata (bus.data_in),
    .re    (ram_re),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (clr) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      wr_ack    <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      fwd_q     <= 1'b0;
      fwd_data  <= '0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      rd_ptr <= rd_ptr_n;
      if (wr_acc && !rd_acc) begin
        count <= count + CNT_W'(1);
      end else if (rd_acc && !wr_acc) begin
        count <= count - CNT_W'(1);
      end
      wr_ack    <= wr_acc;
      overflow  <= bus.wr_en & ~wr_acc;
      underflow <= bus.rd_en & empty;
      fwd_q     <= fwd_hit;
      if (fwd_hit) begin
        fwd_data <= bus.data_in;
      end
    end
  end

  assign bus.data_out    = fwd_q ? fwd_data : ram_rdata;
  assign bus.count       = count;
  assign bus.full        = full;
  assign bus.empty       = empty;
  assign bus.almostfull  = (count >= bus.af_thresh);
  assign bus.almostempty = (count <= bus.ae_thresh);
  assign bus.wr_ack      = wr_ack;
  assign bus.overflow    = overflow;
  assign bus.underflow   = underflow;

endmodule

// File: tb/tb_fifo_prog.sv
// Bench for fifo_prog: a registered-read instance and an FWFT instance, both
// compared against queue-based reference models under directed and random traffic.
module tb_fifo_prog;
  import fifo_prog_pkg::*;

  localparam int W     = 16;
  localparam int DEPTH = 8;
  localparam int CW    = cnt_w(DEPTH);

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  fifo_prog_if #(.FIFO_WIDTH(W), .CNT_W(CW)) s_if ();
  fifo_prog_if #(.FIFO_WIDTH(W), .CNT_W(CW)) f_if ();

  fifo_prog #(.FIFO_WIDTH(W), .FIFO_DEPTH(DEPTH), .FWFT(0)) dut_std (
    .clk (clk), .rst (rst), .bus (s_if.slave)
  );
  fifo_prog #(.FIFO_WIDTH(W), .FIFO_DEPTH(DEPTH), .FWFT(1)) dut_fwft (
    .clk (clk), .rst (rst), .bus (f_if.slave)
  );

  always #5 clk = ~clk;

  // Reference state: contents as queues, expected pulse flags and read data.
  logic [W-1:0] sq[$];
  logic [W-1:0] fq[$];
  logic         s_ack, s_ovf, s_udf;
  logic         f_ack, f_ovf, f_udf;
  logic [W-1:0] s_dout;
  logic [6:0]   exp_flags, obs_flags;

  task automatic std_cycle(input logic wr, input logic rd, input logic fl, input logic [W-1:0] din);
    int n;
    logic racc, wacc;
    n    = sq.size();
    racc = rd && (n != 0);
    wacc = wr && ((n != DEPTH) || racc);
    s_if.wr_en = wr; s_if.rd_en = rd; s_if.flush = fl; s_if.data_in = din;
    if (fl) begin
      sq.delete();
      s_ack = 1'b0; s_ovf = 1'b0; s_udf = 1'b0; s_dout = '0;
    end else begin
      s_ack = wacc; s_ovf = wr && !wacc; s_udf = rd && (n == 0);
      if (racc) s_dout = sq.pop_front();
      if (wacc) sq.push_back(din);
    end
    @(posedge clk); #1;
    s_if.wr_en = 1'b0; s_if.rd_en = 1'b0; s_if.flush = 1'b0;
  endtask

  task automatic fwft_cycle(input logic wr, input logic rd, input logic fl, input logic [W-1:0] din);
    int n;
    logic racc, wacc;
    n    = fq.size();
    racc = rd && (n != 0);
    wacc = wr && ((n != DEPTH) || racc);
    f_if.wr_en = wr; f_if.rd_en = rd; f_if.flush = fl; f_if.data_in = din;
    if (fl) begin
      fq.delete();
      f_ack = 1'b0; f_ovf = 1'b0; f_udf = 1'b0;
    end else begin
      f_ack = wacc; f_ovf = wr && !wacc; f_udf = rd && (n == 0);
      if (racc) void'(fq.pop_front());
      if (wacc) fq.push_back(din);
    end
    @(posedge clk); #1;
    f_if.wr_en = 1'b0; f_if.rd_en = 1'b0; f_if.flush = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    sq.delete(); fq.delete(); s_dout = '0;
    checks++;
    if ({s_if.count, s_if.empty, s_if.full} !== {CW'(0), 1'b1, 1'b0}) begin
      errors++; $display("FAIL reset_status got count=%0d empty=%b full=%b exp 0/1/0", s_if.count, s_if.empty, s_if.full);
    end
    checks++;
    if (s_if.data_out !== 16'h0000) begin
      errors++; $display("FAIL reset_data got %h exp 0000", s_if.data_out);
    end
    checks++;
    if ({s_if.wr_ack, s_if.overflow, s_if.underflow} !== 3'b000) begin
      errors++; $display("FAIL reset_pulses got %b exp 000", {s_if.wr_ack, s_if.overflow, s_if.underflow});
    end
    checks++;
    if ({f_if.count, f_if.empty, f_if.data_out} !== {CW'(0), 1'b1, 16'h0000}) begin
      errors++; $display("FAIL reset_fwft got count=%0d empty=%b data=%h", f_if.count, f_if.empty, f_if.data_out);
    end
  endtask

  task automatic test_fill_overflow();
    for (int i = 0; i < DEPTH; i++) begin
      std_cycle(1'b1, 1'b0, 1'b0, 16'(16'hA000 + i));
      checks++;
      if ({s_if.wr_ack, s_if.count} !== {1'b1, CW'(i + 1)}) begin
        errors++; $display("FAIL fill_%0d got ack=%b count=%0d exp 1/%0d", i, s_if.wr_ack, s_if.count, i + 1);
      end
    end
    checks++;
    if (s_if.full !== 1'b1) begin
      errors++; $display("FAIL full_flag got %b exp 1", s_if.full);
    end
    std_cycle(1'b1, 1'b0, 1'b0, 16'hDEAD);
    checks++;
    if ({s_if.overflow, s_if.wr_ack, s_if.count} !== {1'b1, 1'b0, CW'(DEPTH)}) begin
      errors++; $display("FAIL overflow got ovf=%b ack=%b count=%0d exp 1/0/8", s_if.overflow, s_if.wr_ack, s_if.count);
    end
  endtask

  task automatic test_thresholds();
    std_cycle(1'b0, 1'b0, 1'b1, 16'h0000);
    checks++;
    if ({s_if.count, s_if.empty, s_if.data_out} !== {CW'(0), 1'b1, 16'h0000}) begin
      errors++; $display("FAIL flush got count=%0d empty=%b data=%h", s_if.count, s_if.empty, s_if.data_out);
    end
    s_if.af_thresh = CW'(6); s_if.ae_thresh = CW'(2);
    #1;
    for (int k = 0; k <= DEPTH; k++) begin
      checks++;
      if ({s_if.almostfull, s_if.almostempty} !== {k >= 6, k <= 2}) begin
        errors++; $display("FAIL thresh_at_%0d got af=%b ae=%b exp %b/%b", k, s_if.almostfull, s_if.almostempty, k >= 6, k <= 2);
      end
      if (k < DEPTH) std_cycle(1'b1, 1'b0, 1'b0, 16'(16'hA000 + k));
    end
    // Live threshold changes at count 8, no clock edge in between.
    s_if.af_thresh = CW'(9); s_if.ae_thresh = CW'(DEPTH);
    #1;
    checks++;
    if ({s_if.almostfull, s_if.almostempty} !== 2'b01) begin
      errors++; $display("FAIL thresh_live_hi got af=%b ae=%b exp 0/1", s_if.almostfull, s_if.almostempty);
    end
    s_if.af_thresh = CW'(0); s_if.ae_thresh = CW'(7);
    #1;
    checks++;
    if ({s_if.almostfull, s_if.almostempty} !== 2'b10) begin
      errors++; $display("FAIL thresh_live_lo got af=%b ae=%b exp 1/0", s_if.almostfull, s_if.almostempty);
    end
    s_if.af_thresh = CW'(6); s_if.ae_thresh = CW'(2);
    #1;
  endtask

  task automatic test_full_read_write();
    std_cycle(1'b1, 1'b1, 1'b0, 16'hBEEF);
    checks++;
    if ({s_if.overflow, s_if.wr_ack, s_if.count, s_if.data_out} !== {1'b0, 1'b1, CW'(DEPTH), 16'hA000}) begin
      errors++; $display("FAIL full_rw got ovf=%b ack=%b count=%0d data=%h exp 0/1/8/a000",
                         s_if.overflow, s_if.wr_ack, s_if.count, s_if.data_out);
    end
    for (int i = 0; i < DEPTH; i++) begin
      logic [W-1:0] want;
      want = (i < DEPTH - 1) ? 16'(16'hA001 + i) : 16'hBEEF;
      std_cycle(1'b0, 1'b1, 1'b0, 16'h0000);
      checks++;
      if (s_if.data_out !== want || s_dout !== want) begin
        errors++; $display("FAIL wrap_read_%0d got %h exp %h", i, s_if.data_out, want);
      end
    end
    checks++;
    if ({s_if.count, s_if.empty} !== {CW'(0), 1'b1}) begin
      errors++; $display("FAIL drained got count=%0d empty=%b exp 0/1", s_if.count, s_if.empty);
    end
  endtask

  task automatic test_empty_read_write();
    std_cycle(1'b1, 1'b1, 1'b0, 16'h1234);
    checks++;
    if ({s_if.underflow, s_if.wr_ack, s_if.overflow, s_if.count} !== {1'b1, 1'b1, 1'b0, CW'(1)}) begin
      errors++; $display("FAIL empty_rw got udf=%b ack=%b ovf=%b count=%0d exp 1/1/0/1",
                         s_if.underflow, s_if.wr_ack, s_if.overflow, s_if.count);
    end
    std_cycle(1'b0, 1'b1, 1'b0, 16'h0000);
    checks++;
    if ({s_if.data_out, s_if.count, s_if.underflow} !== {16'h1234, CW'(0), 1'b0}) begin
      errors++; $display("FAIL empty_rw_read got data=%h count=%0d udf=%b exp 1234/0/0", s_if.data_out, s_if.count, s_if.underflow);
    end
    std_cycle(1'b0, 1'b1, 1'b0, 16'h0000);
    checks++;
    if ({s_if.underflow, s_if.data_out} !== {1'b1, 16'h1234}) begin
      errors++; $display("FAIL underflow_hold got udf=%b data=%h exp 1/1234", s_if.underflow, s_if.data_out);
    end
  endtask

  task automatic test_random_std();
    int wr_pct, rd_pct;
    for (int i = 0; i < 400; i++) begin
      wr_pct = ((i / 50) % 2 == 0) ? 75 : 25;
      rd_pct = 100 - wr_pct;
      s_if.af_thresh = CW'($urandom_range(0, 9));
      s_if.ae_thresh = CW'($urandom_range(0, 9));
      std_cycle(1'($urandom_range(0, 99) < wr_pct), 1'($urandom_range(0, 99) < rd_pct),
                1'($urandom_range(0, 39) == 0), 16'($urandom));
      exp_flags = {sq.size() == DEPTH, sq.size() == 0, sq.size() >= int'(s_if.af_thresh),
                   sq.size() <= int'(s_if.ae_thresh), s_ack, s_ovf, s_udf};
      obs_flags = {s_if.full, s_if.empty, s_if.almostfull, s_if.almostempty,
                   s_if.wr_ack, s_if.overflow, s_if.underflow};
      checks++;
      if (s_if.count !== CW'(sq.size())) begin
        errors++; $display("FAIL rnd_count_%0d got %0d exp %0d", i, s_if.count, sq.size());
      end
      checks++;
      if (obs_flags !== exp_flags) begin
        errors++; $display("FAIL rnd_flags_%0d got %b exp %b", i, obs_flags, exp_flags);
      end
      checks++;
      if (s_if.data_out !== s_dout) begin
        errors++; $display("FAIL rnd_data_%0d got %h exp %h", i, s_if.data_out, s_dout);
      end
    end
  endtask

  task automatic test_fwft();
    fwft_cycle(1'b1, 1'b0, 1'b0, 16'h55AA);
    checks++;
    if ({f_if.data_out, f_if.count, f_if.empty} !== {16'h55AA, CW'(1), 1'b0}) begin
      errors++; $display("FAIL fwft_first got data=%h count=%0d empty=%b exp 55aa/1/0", f_if.data_out, f_if.count, f_if.empty);
    end
    fwft_cycle(1'b0, 1'b0, 1'b0, 16'h0000);
    checks++;
    if (f_if.data_out !== 16'h55AA) begin
      errors++; $display("FAIL fwft_hold got %h exp 55aa", f_if.data_out);
    end
    for (int i = 0; i < 4; i++) fwft_cycle(1'b1, 1'b0, 1'b0, 16'(16'h6000 + i));
    checks++;
    if ({f_if.data_out, f_if.count} !== {16'h55AA, CW'(5)}) begin
      errors++; $display("FAIL fwft_fill got data=%h count=%0d exp 55aa/5", f_if.data_out, f_if.count);
    end
    fwft_cycle(1'b0, 1'b1, 1'b0, 16'h0000);
    checks++;
    if ({f_if.data_out, f_if.count} !== {16'h6000, CW'(4)}) begin
      errors++; $display("FAIL fwft_pop got data=%h count=%0d exp 6000/4", f_if.data_out, f_if.count);
    end
    fwft_cycle(1'b1, 1'b0, 1'b0, 16'h7000);
    fwft_cycle(1'b0, 1'b0, 1'b1, 16'h0000);
    checks++;
    if ({f_if.count, f_if.empty, f_if.full} !== {CW'(0), 1'b1, 1'b0}) begin
      errors++; $display("FAIL fwft_flush got count=%0d empty=%b full=%b exp 0/1/0", f_if.count, f_if.empty, f_if.full);
    end
  endtask

  task automatic test_random_fwft();
    int wr_pct;
    for (int i = 0; i < 300; i++) begin
      wr_pct = ((i / 40) % 2 == 0) ? 70 : 30;
      fwft_cycle(1'($urandom_range(0, 99) < wr_pct), 1'($urandom_range(0, 99) < 100 - wr_pct),
                 1'($urandom_range(0, 49) == 0), 16'($urandom));
      checks++;
      if ({f_if.count, f_if.full, f_if.empty} !== {CW'(fq.size()), fq.size() == DEPTH, fq.size() == 0}) begin
        errors++; $display("FAIL frnd_status_%0d got count=%0d full=%b empty=%b exp %0d", i, f_if.count, f_if.full, f_if.empty, fq.size());
      end
      checks++;
      if ({f_if.wr_ack, f_if.overflow, f_if.underflow} !== {f_ack, f_ovf, f_udf}) begin
        errors++; $display("FAIL frnd_pulses_%0d got %b exp %b", i, {f_if.wr_ack, f_if.overflow, f_if.underflow}, {f_ack, f_ovf, f_udf});
      end
      if (fq.size() != 0) begin
        checks++;
        if (f_if.data_out !== fq[0]) begin
          errors++; $display("FAIL frnd_head_%0d got %h exp %h", i, f_if.data_out, fq[0]);
        end
      end
    end
  endtask

  initial begin
    s_if.flush = 1'b0; s_if.wr_en = 1'b0; s_if.rd_en = 1'b0; s_if.data_in = '0;
    s_if.af_thresh = CW'(DEPTH); s_if.ae_thresh = CW'(0);
    f_if.flush = 1'b0; f_if.wr_en = 1'b0; f_if.rd_en = 1'b0; f_if.data_in = '0;
    f_if.af_thresh = CW'(6); f_if.ae_thresh = CW'(2);
    test_reset();
    test_fill_overflow();
    test_thresholds();
    test_full_read_write();
    test_empty_read_write();
    test_random_std();
    test_fwft();
    test_random_fwft();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired before the sequence completed");
    $fatal(1, "watchdog");
  end

endmodule
